// File: rtl/dbus_pkg.sv
// Shared types and constants for the core data-bus bridge.
// Holds the bridge state encoding and byte-mask legality helper.
package dbus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DMEM  = 2'd1,
        ACCEL = 2'd2,
        RESP  = 2'd3
    } dbus_state_e;

    localparam int N_LEGAL_MASKS = 7;

    localparam logic [3:0] LEGAL_MASKS [N_LEGAL_MASKS] = '{
        4'b0001, 4'b0010, 4'b0100, 4'b1000,
        4'b0011, 4'b1100, 4'b1111
    };

    localparam logic [31:0] DBUS_ERR_RDATA = 32'h0;

    // Byte, aligned halfword or full word only.
    function automatic logic mask_legal(input logic [3:0] m);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < N_LEGAL_MASKS; i++) begin
            if (m == LEGAL_MASKS[i]) ok = 1'b1;
        end
        return ok;
    endfunction

endpackage

// File: rtl/dbus_addr_decode.sv
// Combinational slave select and byte-mask check.
// Shared with the accelerator-side bench.
module dbus_addr_decode
    import dbus_pkg::*;
#(
    parameter logic [31:0] ACCEL_BASE = 32'h4000_0000,
    parameter int          ACCEL_AW   = 12
) (
    input  logic [31:0] addr,
    input  logic [3:0]  mask,
    output logic        sel_accel,
    output logic        mask_ok
);

    assign sel_accel = (addr[31:ACCEL_AW] == ACCEL_BASE[31:ACCEL_AW]);
    assign mask_ok   = mask_legal(mask);

endmodule

// File: rtl/dbus_bridge.sv
// Registered bridge from the core data port to data memory
// and the GEMM accelerator window, with bus-error timeout.
module dbus_bridge
    import dbus_pkg::*;
#(
    parameter logic [31:0] ACCEL_BASE = 32'h4000_0000,
    parameter int          ACCEL_AW   = 12,
    parameter int          TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cs,
    input  logic                mem_rd_wr,
    input  logic [3:0]          mask,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_write_data,
    output logic [31:0]         mem_read_data,
    output logic                mem_valid,
    output logic                bus_err,
    output logic                dm_cs,
    output logic                dm_rd_wr,
    output logic [3:0]          dm_mask,
    output logic [31:0]         dm_addr,
    output logic [31:0]         dm_wdata,
    input  logic [31:0]         dm_rdata,
    input  logic                dm_valid,
    output logic                ac_cs,
    output logic                ac_rd_wr,
    output logic [3:0]          ac_mask,
    output logic [ACCEL_AW-1:0] ac_addr,
    output logic [31:0]         ac_wdata,
    input  logic [31:0]         ac_rdata,
    input  logic                ac_valid
);

    // Last wait count before the slave is abandoned.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    dbus_state_e state;
    dbus_state_e state_nxt;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [3:0]  mask_q;
    logic        wr_q;
    logic        err_q;
    logic [7:0]  wait_q;

    logic sel_accel;
    logic mask_ok;
    logic slave_valid;
    logic timed_out;

    dbus_addr_decode #(
        .ACCEL_BASE(ACCEL_BASE),
        .ACCEL_AW  (ACCEL_AW)
    ) u_dec (
        .addr     (mem_addr),
        .mask     (mask),
        .sel_accel(sel_accel),
        .mask_ok  (mask_ok)
    );

    // Only the selected slave's answer is heard.
    assign slave_valid = ((state == DMEM) && dm_valid)
                      || ((state == ACCEL) && ac_valid);
    assign timed_out   = (wait_q == WAIT_LAST);

    // State register; reset drops any slave strobe at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cs) begin
                    if (!mask_ok)       state_nxt = RESP;
                    else if (sel_accel) state_nxt = ACCEL;
                    else                state_nxt = DMEM;
                end
            end
            DMEM, ACCEL: begin
                if (slave_valid || timed_out) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, response capture and wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= DBUS_ERR_RDATA;
            mask_q  <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            wait_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cs) begin
                        addr_q  <= mem_addr;
                        wdata_q <= mem_write_data;
                        mask_q  <= mask;
                        wr_q    <= mem_rd_wr;
                        err_q   <= !mask_ok;
                        rdata_q <= DBUS_ERR_RDATA;
                        wait_q  <= '0;
                    end
                end
                DMEM, ACCEL: begin
                    if (slave_valid) begin
                        rdata_q <= (state == ACCEL) ? ac_rdata : dm_rdata;
                    end else if (timed_out) begin
                        err_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dm_cs    = (state == DMEM);
    assign dm_rd_wr = wr_q;
    assign dm_mask  = mask_q;
    assign dm_addr  = addr_q;
    assign dm_wdata = wdata_q;

    assign ac_cs    = (state == ACCEL);
    assign ac_rd_wr = wr_q;
    assign ac_mask  = mask_q;
    assign ac_addr  = addr_q[ACCEL_AW-1:0];
    assign ac_wdata = wdata_q;

    assign mem_valid     = (state == RESP);
    assign bus_err       = mem_valid && err_q;
    assign mem_read_data = (mem_valid && !err_q) ? rdata_q : DBUS_ERR_RDATA;

endmodule
